// File: rtl/timer_keypad_loader.sv
// Keypad front end for a 4-digit BCD countdown timer (mm:ss); registered outputs.
// Latency: a key edge updates the digits on the next clk edge; START gives a one-cycle load.
// Backpressure: none; one event per rising edge of key_valid, and extra digits are dropped.
//
// Ports:
//   clk, rst (sync, active-low)     : clock and reset
//   key_valid, key_code             : keypad level and code (0..9, CLEAR_CODE, START_CODE)
//   timer_zero                      : counter chain reads 00:00
//   min_tens..sec_ones              : BCD parallel-load values for the four digit counters
//   load, enablen                   : one-cycle load strobe, active-low count enable
//   digit_cnt, running, done_pulse  : entry count, RUN indicator, completion indicator
// Optional: define KEYPAD_PAUSE_EN to let START toggle RUN <-> PAUSE.
module timer_keypad_loader #(
  parameter logic [3:0] CLEAR_CODE = 4'hA,
  parameter logic [3:0] START_CODE = 4'hB,
  parameter int         DONE_HOLD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_zero,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       enablen,
  output logic [2:0] digit_cnt,
  output logic       running,
  output logic       done_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_RUN,
    S_DONE
`ifdef KEYPAD_PAUSE_EN
    , S_PAUSE
`endif
  } state_t;

  state_t     state;
  logic       key_prev;
  logic [1:0] settle;    // blocks timer_zero until the loaded value has reached the chain
  logic [3:0] hold_cnt;

  logic key_evt, is_digit, is_clear, is_start, digits_zero;

  assign key_evt     = key_valid && !key_prev;
  assign is_digit    = (key_code <= 4'd9);
  assign is_clear    = (key_code == CLEAR_CODE);
  assign is_start    = (key_code == START_CODE);
  assign digits_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      key_prev   <= 1'b0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      load       <= 1'b0;
      enablen    <= 1'b1;
      digit_cnt  <= 3'd0;
      running    <= 1'b0;
      done_pulse <= 1'b0;
      settle     <= 2'd0;
      hold_cnt   <= 4'd0;
    end else begin
      key_prev <= key_valid;
      load     <= 1'b0;
      case (state)
        S_IDLE: begin
          // Digits are already zero here, so the shift reduces to a single placement.
          if (key_evt && is_digit) begin
            sec_ones  <= key_code;
            digit_cnt <= 3'd1;
            state     <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (key_evt) begin
            if (is_digit) begin
              if (digit_cnt < 3'd4) begin
                min_tens  <= min_ones;
                min_ones  <= sec_tens;
                sec_tens  <= sec_ones;
                sec_ones  <= key_code;
                digit_cnt <= digit_cnt + 3'd1;
              end
            end else if (is_clear) begin
              {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
              digit_cnt <= 3'd0;
              state     <= S_IDLE;
            end else if (is_start) begin
              if (digits_zero) begin
                digit_cnt <= 3'd0;
                state     <= S_IDLE;
              end else begin
                load    <= 1'b1;
                enablen <= 1'b0;
                running <= 1'b1;
                settle  <= 2'd2;
                state   <= S_RUN;
              end
            end
          end
        end

        S_RUN: begin
          if (key_evt && is_clear) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
            digit_cnt <= 3'd0;
            enablen   <= 1'b1;
            running   <= 1'b0;
            state     <= S_IDLE;
`ifdef KEYPAD_PAUSE_EN
          end else if (key_evt && is_start) begin
            enablen <= 1'b1;
            running <= 1'b0;
            state   <= S_PAUSE;
`endif
          end else if (settle != 2'd0) begin
            settle <= settle - 2'd1;
          end else if (timer_zero) begin
            enablen    <= 1'b1;
            running    <= 1'b0;
            done_pulse <= 1'b1;
            hold_cnt   <= 4'(DONE_HOLD - 1);
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          // Any key aborts; the key itself is consumed, not shifted in.
          if (key_evt || hold_cnt == 4'd0) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
            digit_cnt  <= 3'd0;
            done_pulse <= 1'b0;
            state      <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end

`ifdef KEYPAD_PAUSE_EN
        S_PAUSE: begin
          // Resume does not reload: the downstream counters still hold the remaining time.
          if (key_evt && is_clear) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
            digit_cnt <= 3'd0;
            state     <= S_IDLE;
          end else if (key_evt && is_start) begin
            enablen <= 1'b0;
            running <= 1'b1;
            state   <= S_RUN;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/timer_keypad_loader.md
Name: timer_keypad_loader

Overview:
- Upstream front end of the countdown timer chain (min_tens, min_ones, sec_tens, sec_ones BCD down counters).
- Accepts keypad strobes and shifts BCD digits in from the right, microwave style, holding up to 4 digits.
- On the start key, issues a one-cycle parallel load of all four digit counters, then enables counting.
- Watches the chain's terminal-count flag and reports completion.

Parameters:
- CLEAR_CODE, 4'hA, key_code value meaning clear/stop.
- START_CODE, 4'hB, key_code value meaning start.
- DONE_HOLD, 4, clk cycles done_pulse stays high after the timer reaches zero (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk only.
- key_valid  in  1  level from the keypad decoder, high while a key is held.
- key_code  in  4  0..9 digit, CLEAR_CODE, START_CODE; other codes are ignored.
- timer_zero  in  1  high when the whole counter chain reads 00:00 (from the downstream rco chain).
- min_tens  out  4  BCD load value for the minute-tens counter.
- min_ones  out  4  BCD load value for the minute-ones counter.
- sec_tens  out  4  BCD load value for the seconds-tens counter; values 0..9 are permitted, so 60..99 s entries are passed through unclamped.
- sec_ones  out  4  BCD load value for the seconds-ones counter.
- load  out  1  one-cycle parallel-load pulse to all digit counters.
- enablen  out  1  active-low count enable to the chain.
- digit_cnt  out  3  number of digits entered, 0..4.
- running  out  1  high in RUN state.
- done_pulse  out  1  completion indicator.

Behaviour:
- Reset (rst low at posedge): all digit outputs 0, load 0, enablen 1, digit_cnt 0, running 0, done_pulse 0, state IDLE, key edge register 0.
- Key acceptance:
  - A key is accepted only on the rising edge of key_valid: key_valid high this cycle and low in the registered previous value.
  - Holding a key gives exactly one event. key_code is sampled in the edge cycle.
- States:
  - IDLE: digits 0.
    - Digit key: shift in, go to ENTRY.
    - START with zero value: ignored.
    - CLEAR: no-op.
  - ENTRY, digit key with digit_cnt<4:
    - {min_tens,min_ones,sec_tens,sec_ones} <= {min_ones,sec_tens,sec_ones,key}; digit_cnt+1.
    - Fifth and later digits are ignored; the registers are unchanged.
  - ENTRY, CLEAR: digits 0, digit_cnt 0, go to IDLE.
  - ENTRY, START:
    - If all digits are 0: go to IDLE, no load.
    - Otherwise: load high for exactly the next cycle, enablen low from the same cycle, go to RUN.
    - Digit outputs hold their value for the duration of the load cycle and through RUN.
  - RUN: running 1, enablen 0.
    - Digit keys are ignored.
    - CLEAR: enablen 1, digits 0, digit_cnt 0, go to IDLE.
    - timer_zero high, checked only from the second cycle after load: enablen 1, go to DONE.
  - DONE: done_pulse high for DONE_HOLD cycles, then go to IDLE with digits cleared.
    - Any accepted key during DONE aborts immediately to IDLE. That key is consumed and not shifted.
- Simultaneous events:
  - rst low overrides everything.
  - In RUN, CLEAR takes priority over timer_zero in the same cycle.
- Reset mid-RUN: enablen returns high on that edge and load never asserts.
- Outputs are registered with no combinational path from key_code to load or enablen.

Optional Feature:
- Macro: KEYPAD_PAUSE_EN.
- Defined:
  - START in RUN moves to PAUSE: enablen 1, running 0, digits held.
  - START in PAUSE returns to RUN with enablen 0. No reload; the downstream counters keep their value.
  - CLEAR in PAUSE goes to IDLE.
  - timer_zero is ignored in PAUSE.
- Undefined: START in RUN is ignored and no PAUSE state exists.

Test Plan:
- Reset, then keys 1,3,0 -> min_tens=0, min_ones=1, sec_tens=3, sec_ones=0, digit_cnt=3, enablen=1, load=0.
- Keys 9,9,9,9,5 -> digits stay 9,9,9,9, digit_cnt=4. START -> load high exactly 1 cycle, enablen 0 from that cycle, running 1.
- Keys 7,5 then START -> sec_tens=7, sec_ones=5 loaded unclamped; assert timer_zero 10 cycles later -> enablen 1, done_pulse high 4 cycles, then IDLE with digits 0.
- key_valid held high 20 cycles with code 4 -> exactly one shift, digit_cnt=1. START from IDLE with all-zero value -> no load.
- In RUN, drive CLEAR and timer_zero in the same cycle -> IDLE, done_pulse stays 0. Separately, rst low mid-RUN -> all outputs return to reset values next edge.
- With KEYPAD_PAUSE_EN: keys 2,0, START, START -> enablen 1 and digits held. START again -> enablen 0, no load pulse. Without the macro, the second START changes nothing.
